spi_reg_peripheral: RTL and testbench

SPI_REG_PERIPHERAL -- requirements
Module: spi_reg_peripheral

---
 rtl/spi_reg_pkg.sv | 33 +++
 rtl/spi_sync.sv | 25 ++
 rtl/spi_reg_peripheral.sv | 131 +++++++++++++
 tb/tb_spi_reg_peripheral.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register peripheral: frame layout,
// register addresses and the frame-decoder FSM state.
package spi_reg_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned ADDR_BITS  = 7;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned NUM_REGS   = 5;

    localparam int unsigned CNT_W = $clog2(FRAME_BITS + 1);

    localparam logic [ADDR_BITS-1:0] ADDR_EN_OUT_7_0  = 7'h00;
    localparam logic [ADDR_BITS-1:0] ADDR_EN_OUT_15_8 = 7'h01;
    localparam logic [ADDR_BITS-1:0] ADDR_EN_PWM_7_0  = 7'h02;
    localparam logic [ADDR_BITS-1:0] ADDR_EN_PWM_15_8 = 7'h03;
    localparam logic [ADDR_BITS-1:0] ADDR_PWM_DUTY    = 7'h04;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StCommit
    } state_e;

    function automatic logic [ADDR_BITS-1:0] frame_addr(input logic [FRAME_BITS-1:0] f);
        return f[FRAME_BITS-2 -: ADDR_BITS];
    endfunction

    // A frame only touches the map when it is a write to an implemented address.
    function automatic logic frame_is_write(input logic [FRAME_BITS-1:0] f);
        return f[FRAME_BITS-1] && (frame_addr(f) < ADDR_BITS'(NUM_REGS));
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with a selectable
// value loaded while reset is held.
module spi_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    input  logic rst_val_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{rst_val_i}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 write-only register peripheral: 16-bit frames (R/W, 7-bit
// address, 8-bit data) update five enable/duty registers on chip-select release.
module spi_reg_peripheral
    import spi_reg_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

    logic sclk_s, copi_s, ncs_s;
    logic sclk_prev_q, ncs_prev_q;
    logic sclk_rise, ncs_fall, ncs_rise;

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [FRAME_BITS-1:0]  shift_q;
    logic                   wr_strobe_q;
    logic [DATA_BITS-1:0]   en_out_lo_q, en_out_hi_q, en_pwm_lo_q, en_pwm_hi_q, duty_q;

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk       (clk),
        .rst       (rst),
        .d_i       (sclk),
        .rst_val_i (1'b0),
        .q_o       (sclk_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_copi (
        .clk       (clk),
        .rst       (rst),
        .d_i       (copi),
        .rst_val_i (1'b0),
        .q_o       (copi_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_ncs (
        .clk       (clk),
        .rst       (rst),
        .d_i       (ncs),
        .rst_val_i (1'b1),
        .q_o       (ncs_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b1;
        end else begin
            sclk_prev_q <= sclk_s;
            ncs_prev_q  <= ncs_s;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign ncs_fall  = ~ncs_s & ncs_prev_q;
    assign ncs_rise  = ncs_s & ~ncs_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            shift_q     <= '0;
            wr_strobe_q <= 1'b0;
            en_out_lo_q <= '0;
            en_out_hi_q <= '0;
            en_pwm_lo_q <= '0;
            en_pwm_hi_q <= '0;
            duty_q      <= '0;
        end else begin
            wr_strobe_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (ncs_fall) begin
                        state_q <= StShift;
                        cnt_q   <= '0;
                        shift_q <= '0;
                    end
                end
                StShift: begin
                    if (ncs_rise) begin
                        if (cnt_q == CNT_FULL) begin
                            state_q     <= StCommit;
                            wr_strobe_q <= frame_is_write(shift_q);
                        end else begin
                            state_q <= StIdle;
                        end
                    end else if (sclk_rise && !ncs_s && cnt_q != CNT_FULL) begin
                        // Edges beyond the 16th bit are dropped, keeping the frame intact.
                        shift_q <= {shift_q[FRAME_BITS-2:0], copi_s};
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                StCommit: begin
                    state_q <= StIdle;
                    if (frame_is_write(shift_q)) begin
                        case (frame_addr(shift_q))
                            ADDR_EN_OUT_7_0:  en_out_lo_q <= shift_q[DATA_BITS-1:0];
                            ADDR_EN_OUT_15_8: en_out_hi_q <= shift_q[DATA_BITS-1:0];
                            ADDR_EN_PWM_7_0:  en_pwm_lo_q <= shift_q[DATA_BITS-1:0];
                            ADDR_EN_PWM_15_8: en_pwm_hi_q <= shift_q[DATA_BITS-1:0];
                            ADDR_PWM_DUTY:    duty_q      <= shift_q[DATA_BITS-1:0];
                            default: ;
                        endcase
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign en_reg_out_7_0  = en_out_lo_q;
    assign en_reg_out_15_8 = en_out_hi_q;
    assign en_reg_pwm_7_0  = en_pwm_lo_q;
    assign en_reg_pwm_15_8 = en_pwm_hi_q;
    assign pwm_duty_cycle  = duty_q;
    assign wr_strobe       = wr_strobe_q;

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Directed bench for spi_reg_peripheral: two instances (2- and 3-stage
// synchronisers) share one SPI bus; expected values are hand-computed.
module tb_spi_reg_peripheral;

    logic clk = 1'b0;
    logic rst, sclk, copi, ncs;

    logic [7:0] out_lo_a, out_hi_a, pwm_lo_a, pwm_hi_a, duty_a;
    logic [7:0] out_lo_b, out_hi_b, pwm_lo_b, pwm_hi_b, duty_b;
    logic       wr_a, wr_b;

    int vectors     = 0;
    int miscompares = 0;
    int strobe_a    = 0;
    int strobe_b    = 0;

    spi_reg_peripheral #(.SYNC_STAGES(2)) dut_a (
        .clk             (clk),
        .rst             (rst),
        .sclk            (sclk),
        .copi            (copi),
        .ncs             (ncs),
        .en_reg_out_7_0  (out_lo_a),
        .en_reg_out_15_8 (out_hi_a),
        .en_reg_pwm_7_0  (pwm_lo_a),
        .en_reg_pwm_15_8 (pwm_hi_a),
        .pwm_duty_cycle  (duty_a),
        .wr_strobe       (wr_a)
    );

    spi_reg_peripheral #(.SYNC_STAGES(3)) dut_b (
        .clk             (clk),
        .rst             (rst),
        .sclk            (sclk),
        .copi            (copi),
        .ncs             (ncs),
        .en_reg_out_7_0  (out_lo_b),
        .en_reg_out_15_8 (out_hi_b),
        .en_reg_pwm_7_0  (pwm_lo_b),
        .en_reg_pwm_15_8 (pwm_hi_b),
        .pwm_duty_cycle  (duty_b),
        .wr_strobe       (wr_b)
    );

    always #5 clk = ~clk;

    // Strobe is one clk wide, so one negedge sample per pulse.
    always @(negedge clk) begin
        if (wr_a === 1'b1) strobe_a++;
        if (wr_b === 1'b1) strobe_b++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs_a(input string tag, input logic [7:0] lo, input logic [7:0] hi,
                                input logic [7:0] plo, input logic [7:0] phi,
                                input logic [7:0] dt);
        check({tag, ".out_7_0"}, 32'(out_lo_a), 32'(lo));
        check({tag, ".out_15_8"}, 32'(out_hi_a), 32'(hi));
        check({tag, ".pwm_7_0"}, 32'(pwm_lo_a), 32'(plo));
        check({tag, ".pwm_15_8"}, 32'(pwm_hi_a), 32'(phi));
        check({tag, ".duty"}, 32'(duty_a), 32'(dt));
    endtask

    // Drops ncs and clocks out nbits MSB-first at sclk = clk/8; ncs left low.
    task automatic shift_bits(input logic [15:0] f, input int nbits);
        ncs = 1'b0;
        wait_clk(4);
        for (int i = 0; i < nbits; i++) begin
            copi = (i < 16) ? f[15-i] : 1'b0;
            wait_clk(4);
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
        end
        wait_clk(4);
    endtask

    task automatic end_frame();
        ncs = 1'b1;
        wait_clk(12);
    endtask

    task automatic send_frame(input logic [15:0] f);
        shift_bits(f, 16);
        end_frame();
    endtask

    initial begin
        int s0;
        int lat_a, lat_b;

        rst  = 1'b1;
        sclk = 1'b0;
        copi = 1'b0;
        ncs  = 1'b1;
        wait_clk(3);
        check_regs_a("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        check("reset.wr_strobe", 32'(wr_a), 32'h0);
        rst = 1'b0;
        wait_clk(5);

        s0 = strobe_a;
        send_frame(16'h80F0);
        check_regs_a("wr00", 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00);
        check("wr00.strobes", 32'(strobe_a - s0), 32'd1);

        s0 = strobe_a;
        send_frame(16'h8480);
        send_frame(16'h8201);
        wait_clk(1000);
        check_regs_a("wr04_02.hold", 8'hF0, 8'h00, 8'h01, 8'h00, 8'h80);
        check("wr04_02.strobes", 32'(strobe_a - s0), 32'd2);

        s0 = strobe_a;
        send_frame(16'h0055);
        send_frame(16'hB0AA);
        check_regs_a("ignored", 8'hF0, 8'h00, 8'h01, 8'h00, 8'h80);
        check("ignored.strobes", 32'(strobe_a - s0), 32'd0);

        s0 = strobe_a;
        shift_bits(16'h81AA, 9);
        end_frame();
        check("abort9.strobes", 32'(strobe_a - s0), 32'd0);
        check_regs_a("abort9", 8'hF0, 8'h00, 8'h01, 8'h00, 8'h80);
        shift_bits(16'h813C, 17);
        end_frame();
        check_regs_a("over17", 8'hF0, 8'h3C, 8'h01, 8'h00, 8'h80);
        check("over17.strobes", 32'(strobe_a - s0), 32'd1);

        lat_a = 0;
        lat_b = 0;
        shift_bits(16'h805A, 16);
        ncs = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (lat_a == 0 && out_lo_a !== 8'hF0) lat_a = k;
            if (lat_b == 0 && out_lo_b !== 8'hF0) lat_b = k;
        end
        check("latency.sync2", 32'(lat_a), 32'd4);
        check("latency.sync3", 32'(lat_b), 32'd5);
        check("latency.val_a", 32'(out_lo_a), 32'h5A);
        check("latency.val_b", 32'(out_lo_b), 32'h5A);
        wait_clk(5);

        s0 = strobe_a;
        shift_bits(16'h83FF, 8);
        rst = 1'b1;
        wait_clk(2);
        check_regs_a("midrst.during", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        check("midrst.wr_strobe", 32'(wr_a), 32'h0);
        ncs  = 1'b1;
        sclk = 1'b0;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(10);
        check_regs_a("midrst.after", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        send_frame(16'h83FF);
        check_regs_a("midrst.rewrite", 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00);
        check("midrst.strobes", 32'(strobe_a - s0), 32'd1);

        check("b.out_7_0", 32'(out_lo_b), 32'h00);
        check("b.out_15_8", 32'(out_hi_b), 32'h00);
        check("b.pwm_7_0", 32'(pwm_lo_b), 32'h00);
        check("b.pwm_15_8", 32'(pwm_hi_b), 32'hFF);
        check("b.duty", 32'(duty_b), 32'h00);
        check("b.strobes", 32'(strobe_b), 32'd6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
